buffer_reader: RTL and testbench

//   Read-side sequencer for the dual-port buffer: streams a programmed run of words out of it.

---
 rtl/buf_pkg.sv | 22 ++
 rtl/buf_rd_fifo2.sv | 66 ++++++
 rtl/buffer_reader.sv | 146 ++++++++++++++
 tb/tb_buffer_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_pkg.sv
// Shared types and constants for the buffer read-side sequencer.
// FSM state encoding and the capture FIFO depth live here so the top and the FIFO agree.
package buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } buf_rd_state_t;

    localparam int BUF_RD_FIFO_DEPTH = 2;
    localparam int BUF_RD_CNT_W      = $clog2(BUF_RD_FIFO_DEPTH + 1);

    // Occupancy seen by the issue rule: words held plus the word still in the buffer's read pipe.
    function automatic logic [BUF_RD_CNT_W:0] rd_occupancy(
        input logic [BUF_RD_CNT_W-1:0] fifo_cnt,
        input logic                    inflight
    );
        return (BUF_RD_CNT_W + 1)'(fifo_cnt) + (BUF_RD_CNT_W + 1)'(inflight);
    endfunction

endpackage

// File: rtl/buf_rd_fifo2.sv
// Two-entry register FIFO holding {last, data} words captured from the buffer read port.
// Entry 0 is always the head, so the stream output comes straight from a register.
module buf_rd_fifo2
    import buf_pkg::*;
#(
    parameter int G_WIDTH = 9
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [G_WIDTH-1:0]      push_data_i,
    input  logic                    pop_i,
    output logic [BUF_RD_CNT_W-1:0] count_o,
    output logic [G_WIDTH-1:0]      head_o
);

    logic [G_WIDTH-1:0]      entry0_q, entry0_d;
    logic [G_WIDTH-1:0]      entry1_q, entry1_d;
    logic [BUF_RD_CNT_W-1:0] count_q, count_d;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (count_q == '0) begin
                    entry0_d = push_data_i;
                end else begin
                    entry1_d = push_data_i;
                end
                count_d = count_q + BUF_RD_CNT_W'(1);
            end
            2'b01: begin
                entry0_d = entry1_q;
                count_d  = count_q - BUF_RD_CNT_W'(1);
            end
            2'b11: begin
                // Pop is only ever requested with a non-empty FIFO, so count stays put.
                if (count_q == BUF_RD_CNT_W'(1)) begin
                    entry0_d = push_data_i;
                end else begin
                    entry0_d = entry1_q;
                    entry1_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = entry0_q;

endmodule

// File: rtl/buffer_reader.sv
// Read-side sequencer: issues a run of buffer reads and streams the words out on valid/ready with last.
// Optional feature macro BUF_RD_STRIDE_EN adds a stride_i port; otherwise addresses step by one.
module buffer_reader
    import buf_pkg::*;
#(
    parameter int G_BUF_ADDR_WIDTH = 10,
    parameter int G_BUF_DATA_WIDTH = 8,
    parameter int G_LEN_WIDTH      = G_BUF_ADDR_WIDTH + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [G_BUF_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [G_LEN_WIDTH-1:0]      len_i,
`ifdef BUF_RD_STRIDE_EN
    input  logic [G_BUF_ADDR_WIDTH-1:0] stride_i,
`endif
    output logic [G_BUF_ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [G_BUF_DATA_WIDTH-1:0] rd_data_i,
    output logic [G_BUF_DATA_WIDTH-1:0] data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        last_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int AW = G_BUF_ADDR_WIDTH;
    localparam int DW = G_BUF_DATA_WIDTH;
    localparam int LW = G_LEN_WIDTH;

    buf_rd_state_t      state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [LW-1:0]      remaining_q, remaining_d;
    logic               inflight_q, inflight_d;
    logic               inflight_last_q, inflight_last_d;
    logic               done_q, done_d;
    logic [AW-1:0]      step;

    logic [BUF_RD_CNT_W-1:0] fifo_count;
    logic [DW:0]             fifo_head;
    logic                    pop;
    logic                    issue;

`ifdef BUF_RD_STRIDE_EN
    logic [AW-1:0] stride_q, stride_d;
    assign step = stride_q;
`else
    assign step = AW'(1);
`endif

    assign valid_o = (fifo_count != '0);
    assign pop     = valid_o & ready_i;

    // Counting the pop lets a full FIFO keep issuing while the consumer drains it, so no bubbles.
    assign issue = (state_q == RUN) &&
                   (rd_occupancy(fifo_count, inflight_q) < ((BUF_RD_CNT_W + 1)'(2) + (BUF_RD_CNT_W + 1)'(pop)));

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        done_d          = 1'b0;
        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == LW'(1));
`ifdef BUF_RD_STRIDE_EN
        stride_d        = stride_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d     = RUN;
                        addr_d      = base_addr_i;
                        remaining_d = len_i;
`ifdef BUF_RD_STRIDE_EN
                        stride_d    = stride_i;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = addr_q + step;
                    remaining_d = remaining_q - LW'(1);
                    if (remaining_q == LW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && fifo_head[DW]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
`ifdef BUF_RD_STRIDE_EN
            stride_q        <= '0;
`endif
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
`ifdef BUF_RD_STRIDE_EN
            stride_q        <= stride_d;
`endif
        end
    end

    // The buffer answers one cycle after the address, which is exactly when inflight is set.
    buf_rd_fifo2 #(
        .G_WIDTH (DW + 1)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, rd_data_i}),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign rd_addr_o = addr_q;
    assign data_o    = fifo_head[DW-1:0];
    assign last_o    = fifo_head[DW];
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;

endmodule

// File: tb/tb_buffer_reader.sv
// Scoreboard bench for buffer_reader: a buffer model, a run-level reference model and checks on every cycle.
module tb_buffer_reader;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int LW = 11;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [LW-1:0] len_i;
    logic [AW-1:0] stride_i;
    logic [AW-1:0] rd_addr_o;
    logic [DW-1:0] rd_data_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;
    logic          busy_o;
    logic          done_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [DEPTH];

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    bit    busy_m     = 1'b0;
    bit    done_exp   = 1'b0;
    bit    prev_stall = 1'b0;
    int    hs_count   = 0;

    int    rdy_mode = 0;
    int    pat_i    = 0;
    bit    pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    // Buffer with a one-cycle registered read.
    always @(posedge clk) rd_data_i <= mem[rd_addr_o];

    buffer_reader #(
        .G_BUF_ADDR_WIDTH (AW),
        .G_BUF_DATA_WIDTH (DW),
        .G_LEN_WIDTH      (LW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
`ifdef BUF_RD_STRIDE_EN
        .stride_i    (stride_i),
`endif
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int model_step();
`ifdef BUF_RD_STRIDE_EN
        return int'(stride_i);
`else
        return 1;
`endif
    endfunction

    // Reference model: a run is a list of words mem[(base + i*step) mod DEPTH], the last one tagged.
    always @(negedge clk) begin
        beat_t e;
        bit    nd;
        bit    nb;
        int    stp;
        if (rst_i) begin
            exp_q.delete();
            busy_m     = 1'b0;
            done_exp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            nd = 1'b0;
            nb = busy_m;
            check("busy_o", 32'(busy_o), 32'(busy_m));
            check("done_o", 32'(done_o), 32'(done_exp));
            if (prev_stall) check("stall_hold_valid", 32'(valid_o), 32'd1);
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=no_beat at %0t", {last_o, data_o}, $time);
                end else begin
                    e = exp_q[0];
                    check("beat_data", 32'(data_o), 32'(e.data));
                    check("beat_last", 32'(last_o), 32'(e.last));
                    if (ready_i) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                        if (e.last) begin
                            nd = 1'b1;
                            nb = 1'b0;
                        end
                    end
                end
            end
            if (!busy_m && start_i) begin
                if (len_i == '0) begin
                    nd = 1'b1;
                end else begin
                    stp = model_step();
                    for (int i = 0; i < int'(len_i); i++) begin
                        e.last = (i == int'(len_i) - 1);
                        e.data = mem[(int'(base_addr_i) + i * stp) % DEPTH];
                        exp_q.push_back(e);
                    end
                    nb = 1'b1;
                end
            end
            prev_stall = valid_o && !ready_i;
            busy_m     = nb;
            done_exp   = nd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: ready_i = 1'b1;
            1: begin ready_i = pat[pat_i % 4]; pat_i++; end
            default: ready_i = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic start_run(input int base, input int len, input int stride);
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        len_i       = LW'(len);
        stride_i    = AW'(stride);
        tick();
        start_i     = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_m || exp_q.size() != 0 || done_exp) && n < 4000) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < 4000), 32'd1);
        tick();
    endtask

    // Ready held high: one address per cycle from T+1, first beat at T+3.
    task automatic directed(input int base, input int len, input int stride);
        rdy_mode = 0;
        start_run(base, len, stride);
        for (int k = 0; k < len; k++) begin
            check("rd_addr", 32'(rd_addr_o), 32'((base + k * stride) % DEPTH));
            if (k < 3) check("first_valid_timing", 32'(valid_o), 32'(k == 2));
            tick();
        end
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
        check({tag, "_data"},    32'(data_o),    32'd0);
        check({tag, "_valid"},   32'(valid_o),   32'd0);
        check({tag, "_last"},    32'(last_o),    32'd0);
        check({tag, "_busy"},    32'(busy_o),    32'd0);
        check({tag, "_done"},    32'(done_o),    32'd0);
    endtask

    initial begin
        int hs0;
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0; stride_i = AW'(1); ready_i = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        directed(5, 4, 1);
        directed(1022, 4, 1);

        rdy_mode = 1; pat_i = 0;
        start_run(100, 8, 1);
        wait_idle();
        rdy_mode = 0;

        start_run(40, 0, 1);
        check("zero_len_valid", 32'(valid_o), 32'd0);
        check("zero_len_busy",  32'(busy_o),  32'd0);
        tick();
        check("zero_len_valid2", 32'(valid_o), 32'd0);
        wait_idle();

        start_run(200, 6, 1);
        hs0 = hs_count;
        n = 0;
        while (hs_count - hs0 < 3 && n < 50) begin tick(); n++; end
        check("midrun_reach_3_beats", 32'(n < 50), 32'd1);
        rst_i = 1'b1;
        ready_i = 1'b0;
        tick();
        rst_i = 1'b0;
        check_all_zero("midrun_reset");
        directed(300, 5, 1);

`ifdef BUF_RD_STRIDE_EN
        directed(0, 4, 3);
        directed(10, 3, 0);
`endif

        start_run(50, 6, 1);
        start_i = 1'b1; base_addr_i = AW'(900); len_i = LW'(3);
        tick(); tick();
        start_i = 1'b0;
        wait_idle();

        rdy_mode = 2;
        for (int r = 0; r < 25; r++) begin
            start_run(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)), int'($urandom_range(0, 7)));
            for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
                start_i     = 1'($urandom_range(0, 1));
                base_addr_i = AW'($urandom);
                len_i       = LW'($urandom_range(0, 5));
                tick();
            end
            start_i = 1'b0;
            wait_idle();
        end

        start_run(7, DEPTH, 1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
